// File: rtl/attosoc_ledio.sv
// attosoc_ledio: memory-mapped LED output register block with blink and optional PWM dimming
//   clk, rst          : single rising-edge clock, synchronous active-high reset
//   mem_valid/ready   : request / one-cycle acknowledge (ready never asserted for a miss)
//   mem_addr/wdata    : byte address and write data
//   mem_wstrb         : byte strobes, all-zero means read
//   mem_rdata         : read data, zero whenever mem_ready is low
//   led               : registered LED drive
//   Define ATTOSOC_LEDIO_PWM_EN to build in per-LED 4-bit PWM dimming at offset 0x20.
module attosoc_ledio #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int BLINK_DIV = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic [7:0]  led
);
  logic [7:0] r_out, r_mask, r_led;
  logic r_ready;
  logic [31:0] r_rdata;
  logic [BLINK_DIV-1:0] r_blink;
  logic w_hit, w_acc, w_wr, w_w0, w_phase, w_unused;
  logic [3:0] w_off;
  logic [7:0] w_pwm_on, w_led_next, w_wd;
  logic [31:0] w_duty, w_rd;
  assign w_hit = mem_valid & (mem_addr[31:6] == BASE_ADDR[31:6]);
  // An access is accepted only while the previous acknowledge is not being presented.
  assign w_acc = w_hit & ~r_ready;
  assign w_wr = w_acc & |mem_wstrb;
  assign w_w0 = w_wr & mem_wstrb[0];
  assign w_off = mem_addr[5:2];
  assign w_wd = mem_wdata[7:0];
  assign w_phase = r_blink[BLINK_DIV-1];
  assign w_unused = ^{mem_addr[1:0], mem_wdata[31:8]};
`ifdef ATTOSOC_LEDIO_PWM_EN
  logic [3:0] r_pwm_cnt;
  logic [31:0] r_duty;
  always_ff @(posedge clk)
    if (rst) begin
      r_pwm_cnt <= '0;
      r_duty <= '1;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
      for (int b = 0; b < 4; b++)
        if (w_wr && w_off == 4'h8 && mem_wstrb[b]) r_duty[8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  for (genvar i = 0; i < 8; i++) begin : g_pwm
    assign w_pwm_on[i] = r_pwm_cnt <= r_duty[4*i +: 4];
  end
  assign w_duty = r_duty;
`else
  assign w_pwm_on = 8'hFF;
  assign w_duty = '0;
`endif
  always_comb begin
    w_rd = '0;
    case (w_off)
      4'h0: w_rd = {24'b0, r_out};
      4'h4: w_rd = {24'b0, r_mask};
      4'h5: w_rd = {16'b0, r_led, 7'b0, w_phase};
      4'h8: w_rd = w_duty;
      default: w_rd = '0;
    endcase
  end
  assign w_led_next = r_out & ~(r_mask & {8{w_phase}}) & w_pwm_on;
  always_ff @(posedge clk)
    if (rst) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_out <= '0;
      r_mask <= '0;
      r_blink <= '0;
      r_led <= '0;
    end else begin
      r_ready <= w_acc;
      // Read data is captured only for accepted reads, so it is zero whenever ready is low.
      r_rdata <= (w_acc && mem_wstrb == 4'b0) ? w_rd : '0;
      r_blink <= r_blink + {{(BLINK_DIV-1){1'b0}}, 1'b1};
      r_led <= w_led_next;
      if (w_w0)
        case (w_off)
          4'h0: r_out <= w_wd;
          4'h1: r_out <= r_out | w_wd;
          4'h2: r_out <= r_out & ~w_wd;
          4'h3: r_out <= r_out ^ w_wd;
          4'h4: r_mask <= w_wd;
          default: r_out <= r_out;
        endcase
    end
  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign led = r_led;
endmodule
